// File: rtl/reg_byte_tx_pkg.sv
// Shared types for the register-to-byte transmitter: word, byte and FSM state encodings.
package types;

  typedef logic [31:0] register_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE_LOW = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_t;

endpackage

// File: rtl/reg_byte_tx_synchroniser.sv
// Two-flop synchroniser for signals arriving from another clock domain.
module synchroniser #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reg_byte_tx.sv
// Sends a captured 32-bit word LSB-byte first over a four-phase byte_valid/ack handshake.
// state   | meaning
// IDLE    | waiting for load; byte_out holds last byte
// PRE_LOW | word captured, waiting for ack to be low before presenting a byte
// WAIT_HI | byte presented, waiting for ack to rise
// WAIT_LO | byte withdrawn, waiting for ack to fall
module reg_byte_tx
  import types::*;
#(
  parameter int NUM_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  register_t reg_in,
  input  logic      ack_in,
  output byte_t     byte_out,
  output logic      byte_valid,
  output logic      busy,
  output logic      done,
  output logic      timeout_err
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      IDX_LAST = 2'(NUM_BYTES - 1);

  tx_state_t     state;
  register_t     shift_q;
  logic [1:0]    index;
  logic [CW-1:0] cnt;
  logic          ack_s;
  logic          tmo;

  synchroniser #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_in),
    .q     (ack_s)
  );

  assign tmo = (cnt == CNT_LAST);

  // Handshake progress is checked before the timeout so a completing ack wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_q     <= '0;
      index       <= '0;
      cnt         <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (load) begin
            shift_q     <= reg_in;
            index       <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= PRE_LOW;
          end
        end
        PRE_LOW: begin
          if (!ack_s) begin
            byte_out   <= shift_q[7:0];
            byte_valid <= 1'b1;
            cnt        <= '0;
            state      <= WAIT_HI;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            byte_valid  <= 1'b0;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        WAIT_HI: begin
          if (ack_s) begin
            byte_valid <= 1'b0;
            cnt        <= '0;
            state      <= WAIT_LO;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            byte_valid  <= 1'b0;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            cnt <= '0;
            if (index == IDX_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              shift_q    <= {8'h00, shift_q[31:8]};
              index      <= index + 2'd1;
              byte_out   <= shift_q[15:8];
              byte_valid <= 1'b1;
              state      <= WAIT_HI;
            end
          end else if (tmo) begin
            timeout_err <= 1'b1;
            byte_valid  <= 1'b0;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          byte_valid <= 1'b0;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_byte_tx.sv
// Scoreboard bench for reg_byte_tx: a 4-byte/long-timeout instance and a 1-byte/16-cycle-timeout instance.
module tb_reg_byte_tx;
  import types::*;

  typedef struct packed {
    logic  is_done;
    byte_t data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      reset;
  logic      load_a, ack_a, bv_a, busy_a, done_a, terr_a;
  register_t reg_a;
  byte_t     bo_a;
  logic      load_b, ack_b, bv_b, busy_b, done_b, terr_b;
  register_t reg_b;
  byte_t     bo_b;

  reg_byte_tx #(.NUM_BYTES(4), .TIMEOUT_CYCLES(1000)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .reg_in(reg_a), .ack_in(ack_a),
    .byte_out(bo_a), .byte_valid(bv_a), .busy(busy_a), .done(done_a), .timeout_err(terr_a)
  );

  reg_byte_tx #(.NUM_BYTES(1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .reg_in(reg_b), .ack_in(ack_b),
    .byte_out(bo_b), .byte_valid(bv_b), .busy(busy_b), .done(done_b), .timeout_err(terr_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input exp_t exp, input exp_t act);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got done=%b byte=%h expected done=%b byte=%h",
               name, act.is_done, act.data, exp.is_done, exp.data);
    end
  endtask

  task automatic unexpected(input string name, input exp_t act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got done=%b byte=%h expected no event", name, act.is_done, act.data);
  endtask

  // Monitors: each byte_valid rise and each done pulse consumes one scoreboard entry.
  logic pv_a = 1'b0, pd_a = 1'b0, pv_b = 1'b0, pd_b = 1'b0;
  always @(negedge clk) begin
    if (bv_a && !pv_a) begin
      if (q_a.size() == 0) unexpected("a_byte", {1'b0, bo_a});
      else score("a_byte", q_a.pop_front(), {1'b0, bo_a});
    end
    if (done_a) begin
      if (q_a.size() == 0) unexpected("a_done", {1'b1, 8'h00});
      else score("a_done", q_a.pop_front(), {1'b1, 8'h00});
      if (pd_a) check("a_done_width", 32'd2, 32'd1);
    end
    if (bv_b && !pv_b) begin
      if (q_b.size() == 0) unexpected("b_byte", {1'b0, bo_b});
      else score("b_byte", q_b.pop_front(), {1'b0, bo_b});
    end
    if (done_b) begin
      if (q_b.size() == 0) unexpected("b_done", {1'b1, 8'h00});
      else score("b_done", q_b.pop_front(), {1'b1, 8'h00});
      if (pd_b) check("b_done_width", 32'd2, 32'd1);
    end
    pv_a = bv_a; pd_a = done_a; pv_b = bv_b; pd_b = done_b;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bv_a;
      1:       return busy_a;
      2:       return bv_b;
      default: return busy_b;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input logic val);
    int n = 0;
    while (sig(sel) !== val && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: wait expired, got %b expected %b", name, sig(sel), val);
    end
  endtask

  task automatic set_ack(input int which, input logic v);
    if (which == 0) ack_a = v;
    else ack_b = v;
  endtask

  // One full byte handshake with the ack edges placed at a random phase.
  task automatic hs(input int which);
    @(negedge clk);
    wait_for(which == 0 ? "a_valid_rise" : "b_valid_rise", which * 2, 1'b1);
    check(which == 0 ? "a_busy_during" : "b_busy_during", sig(which * 2 + 1), 1'b1);
    #($urandom_range(1, 4));
    set_ack(which, 1'b1);
    @(negedge clk);
    wait_for(which == 0 ? "a_valid_fall" : "b_valid_fall", which * 2, 1'b0);
    #($urandom_range(1, 4));
    set_ack(which, 1'b0);
  endtask

  task automatic push_word(input int which, input register_t w, input int nb);
    register_t t = w;
    for (int i = 0; i < nb; i++) begin
      if (which == 0) q_a.push_back({1'b0, t[7:0]});
      else q_b.push_back({1'b0, t[7:0]});
      t = t >> 8;
    end
    if (which == 0) q_a.push_back({1'b1, 8'h00});
    else q_b.push_back({1'b1, 8'h00});
  endtask

  task automatic pulse_load_a(input register_t w);
    @(posedge clk); #1;
    load_a = 1'b1; reg_a = w;
    @(posedge clk); #1;
    load_a = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load_a = 1'b1; reg_a = 32'hDEADBEEF; ack_a = 1'b0;
    load_b = 1'b1; reg_b = 32'h000000EE; ack_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_out", bo_a, 8'h00);
    check("rst_byte_valid", bv_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_timeout_err", terr_a, 1'b0);
    check("rst_b_busy", busy_b, 1'b0);
    reset = 1'b0; load_a = 1'b0; load_b = 1'b0;
    @(posedge clk); #1;
    check("rst_load_ignored", busy_a, 1'b0);

    // Word D4,C3,B2,A1 with exact load and ack latencies on the first byte.
    push_word(0, 32'hA1B2C3D4, 4);
    @(posedge clk); #1;
    load_a = 1'b1; reg_a = 32'hA1B2C3D4;
    @(posedge clk); #1;
    load_a = 1'b0;
    check("a_busy_after_load", busy_a, 1'b1);
    check("a_valid_before_n1", bv_a, 1'b0);
    @(posedge clk); #1;
    check("a_load_to_valid", bv_a, 1'b1);
    @(negedge clk);
    #($urandom_range(1, 4));
    ack_a = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("a_ack_valid_held", bv_a, 1'b1);
    @(posedge clk); #1;
    check("a_ack_to_drop", bv_a, 1'b0);
    @(negedge clk);
    #($urandom_range(1, 4));
    ack_a = 1'b0;
    for (int i = 0; i < 3; i++) hs(0);
    wait_for("a_idle_after_word", 1, 1'b0);
    check("a_out_held_idle", bo_a, 8'hA1);

    // A load mid-transfer must not disturb the word in flight.
    push_word(0, 32'h0F1E2D3C, 4);
    pulse_load_a(32'h0F1E2D3C);
    hs(0);
    pulse_load_a(32'h11223344);
    for (int i = 0; i < 3; i++) hs(0);
    wait_for("a_idle_after_ignored", 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("a_ignored_load_not_queued", busy_a, 1'b0);

    // ack already high at load: block parks in PRE_LOW until it falls.
    ack_a = 1'b1;
    repeat (3) @(posedge clk);
    push_word(0, 32'hCAFEBABE, 4);
    pulse_load_a(32'hCAFEBABE);
    repeat (5) @(posedge clk);
    #1;
    check("a_prelow_valid", bv_a, 1'b0);
    check("a_prelow_busy", busy_a, 1'b1);
    @(negedge clk);
    ack_a = 1'b0;
    for (int i = 0; i < 4; i++) hs(0);
    wait_for("a_idle_after_prelow", 1, 1'b0);

    // Reset during byte 2 aborts without done; load alongside reset is dropped.
    q_a.push_back({1'b0, 8'h04});
    q_a.push_back({1'b0, 8'h03});
    pulse_load_a(32'h01020304);
    hs(0);
    @(negedge clk);
    wait_for("a_byte2_valid", 0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; load_a = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_byte_out", bo_a, 8'h00);
    check("mid_rst_byte_valid", bv_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    reset = 1'b0; load_a = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_load_ignored", busy_a, 1'b0);

    // Timeout on the 1-byte instance: ack never rises.
    q_b.push_back({1'b0, 8'hAB});
    @(posedge clk); #1;
    load_b = 1'b1; reg_b = 32'h000000AB;
    @(posedge clk); #1;
    load_b = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("b_valid_before_tmo", bv_b, 1'b1);
    check("b_err_before_tmo", terr_b, 1'b0);
    @(posedge clk); #1;
    check("b_valid_at_tmo", bv_b, 1'b0);
    check("b_err_at_tmo", terr_b, 1'b1);
    check("b_busy_at_tmo", busy_b, 1'b0);
    check("b_done_at_tmo", done_b, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("b_err_sticky", terr_b, 1'b1);

    // Next load clears the error and sends the single byte 55.
    push_word(1, 32'h00000055, 1);
    @(posedge clk); #1;
    load_b = 1'b1; reg_b = 32'h00000055;
    @(posedge clk); #1;
    load_b = 1'b0;
    check("b_err_cleared", terr_b, 1'b0);
    hs(1);
    wait_for("b_idle_after_byte", 3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("b_err_still_clear", terr_b, 1'b0);

    @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
